// File: rtl/cfg_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cfg_reg_arbiter
// Purpose  : Holds the five PWM/output configuration registers and
//            round-robin arbitrates write access between port A (SPI frame
//            decoder) and port B (on-chip sequencer). Each accepted write
//            goes IDLE -> COMMIT -> ACK, so one write completes every 3 cycles.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req_a/addr_a/wdata_a/gnt_a - port A request, address, data, grant
//            req_b/addr_b/wdata_b/gnt_b - port B request, address, data, grant
//            err                 - pulses with a grant when that write was rejected
//            busy                - high in COMMIT and ACK
//            en_reg_out_7_0 .. pwm_duty_cycle - registers at 0x00..0x04
// Options  : CFG_ARB_LOCK_EN     - adds a port-A-only lock register at 0x05;
//                                  while lock=1 every port B write is rejected
// Revision : 1.0 - initial release
// ============================================================================
module cfg_reg_arbiter #(
    parameter int NREGS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic [6:0] addr_a,
    input  logic [7:0] wdata_a,
    output logic       gnt_a,
    input  logic       req_b,
    input  logic [6:0] addr_b,
    input  logic [7:0] wdata_b,
    output logic       gnt_b,
    output logic       err,
    output logic       busy,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    localparam logic c_PORT_A = 1'b0;
    localparam logic c_PORT_B = 1'b1;

    state_t     state_q, state_d;
    logic       win_q, win_d;          // port that owns the write in flight
    logic       last_q, last_d;        // last_winner, resets to port B
    logic [6:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       rej_q, rej_d;
    logic [7:0] regs_q [NREGS];
    logic [7:0] regs_d [NREGS];

    logic       w_reg_sel;
    logic       w_lock_sel;
    logic       w_blocked;

`ifdef CFG_ARB_LOCK_EN
    logic       lock_q, lock_d;

    assign w_lock_sel = (addr_q == 7'h05) && (win_q == c_PORT_A);
    assign w_blocked  = (win_q == c_PORT_B) && lock_q;
`else
    assign w_lock_sel = 1'b0;
    assign w_blocked  = 1'b0;
`endif

    assign w_reg_sel = ({25'd0, addr_q} < NREGS);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rej_d   = rej_q;
        regs_d  = regs_q;
`ifdef CFG_ARB_LOCK_EN
        lock_d  = lock_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // On a tie the port that did not win last time goes first.
                if (req_a && (!req_b || (last_q == c_PORT_B))) begin
                    win_d   = c_PORT_A;
                    addr_d  = addr_a;
                    wdata_d = wdata_a;
                    state_d = S_COMMIT;
                end else if (req_b) begin
                    win_d   = c_PORT_B;
                    addr_d  = addr_b;
                    wdata_d = wdata_b;
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (w_blocked) begin
                    rej_d = 1'b1;
                end else if (w_reg_sel) begin
                    for (int i = 0; i < NREGS; i++) begin
                        if (addr_q == 7'(i)) begin
                            regs_d[i] = wdata_q;
                        end
                    end
                end else if (w_lock_sel) begin
`ifdef CFG_ARB_LOCK_EN
                    lock_d = wdata_q[0];
`endif
                end else begin
                    rej_d = 1'b1;
                end
                last_d  = win_q;
                state_d = S_ACK;
            end
            S_ACK: begin
                rej_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            win_q   <= c_PORT_A;
            last_q  <= c_PORT_B;
            addr_q  <= 7'd0;
            wdata_q <= 8'd0;
            rej_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 8'h00;
            end
`ifdef CFG_ARB_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rej_q   <= rej_d;
            regs_q  <= regs_d;
`ifdef CFG_ARB_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    // Grant is suppressed while reset is asserted so an aborted write never
    // acknowledges; the requester keeps req high and is served afterwards.
    assign gnt_a = (state_q == S_ACK) && (win_q == c_PORT_A) && !rst;
    assign gnt_b = (state_q == S_ACK) && (win_q == c_PORT_B) && !rst;
    assign err   = (state_q == S_ACK) && rej_q && !rst;
    assign busy  = (state_q != S_IDLE);

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];

endmodule
`default_nettype wire

// File: tb/tb_cfg_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfg_reg_arbiter
// Purpose  : Directed self-checking bench for cfg_reg_arbiter: reset values,
//            write latency, round-robin contention, invalid address, reset
//            during COMMIT and the optional CFG_ARB_LOCK_EN lock register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfg_reg_arbiter;

    logic       clk;
    logic       rst;
    logic       req_a, req_b;
    logic [6:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       gnt_a, gnt_b, err, busy;
    logic [7:0] r0, r1, r2, r3, r4;

    int n_pass  = 0;
    int n_total = 0;

    cfg_reg_arbiter #(.NREGS(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_a           (req_a),
        .addr_a          (addr_a),
        .wdata_a         (wdata_a),
        .gnt_a           (gnt_a),
        .req_b           (req_b),
        .addr_b          (addr_b),
        .wdata_b         (wdata_b),
        .gnt_b           (gnt_b),
        .err             (err),
        .busy            (busy),
        .en_reg_out_7_0  (r0),
        .en_reg_out_15_8 (r1),
        .en_reg_pwm_7_0  (r2),
        .en_reg_pwm_15_8 (r3),
        .pwm_duty_cycle  (r4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic check_regs(input string tag, input logic [39:0] exp);
        check({tag, " r0"}, {24'd0, r0}, {24'd0, exp[39:32]});
        check({tag, " r1"}, {24'd0, r1}, {24'd0, exp[31:24]});
        check({tag, " r2"}, {24'd0, r2}, {24'd0, exp[23:16]});
        check({tag, " r3"}, {24'd0, r3}, {24'd0, exp[15:8]});
        check({tag, " r4"}, {24'd0, r4}, {24'd0, exp[7:0]});
    endtask

    // Called at a negedge with the bus idle; returns at the negedge after the
    // grant cycle, i.e. with the DUT back in IDLE.
    task automatic do_write(input string tag, input logic port, input logic [6:0] a,
                            input logic [7:0] d, output logic e);
        logic seen;
        logic both;
        seen = 1'b0;
        both = 1'b0;
        e    = 1'b0;
        if (port) begin req_b = 1'b1; addr_b = a; wdata_b = d; end
        else      begin req_a = 1'b1; addr_a = a; wdata_a = d; end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (port ? gnt_b : gnt_a) begin
                seen = 1'b1;
                e    = err;
                both = gnt_a & gnt_b;
                break;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        check({tag, " grant"}, {31'd0, seen}, 32'd1);
        check({tag, " excl"}, {31'd0, both}, 32'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic       e;
    logic       gport [8];
    int         gcyc  [8];
    int         ng;
    int         overlap;

    initial begin
        rst = 1'b1;
        req_a = 1'b0; addr_a = 7'd0; wdata_a = 8'd0;
        req_b = 1'b0; addr_b = 7'd0; wdata_b = 8'd0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_regs("reset", 40'h00_00_00_00_00);
        check("reset gnt_a", {31'd0, gnt_a}, 32'd0);
        check("reset gnt_b", {31'd0, gnt_b}, 32'd0);
        check("reset err",   {31'd0, err},   32'd0);
        check("reset busy",  {31'd0, busy},  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single write and latency: sampled at edge N
        req_a = 1'b1; addr_a = 7'h04; wdata_a = 8'h80;
        @(negedge clk);                         // COMMIT cycle
        check("lat busy",   {31'd0, busy},  32'd1);
        check("lat gnt0",   {31'd0, gnt_a}, 32'd0);
        check("lat duty0",  {24'd0, r4},    32'h00);
        @(negedge clk);                         // ACK cycle
        check("lat duty1",  {24'd0, r4},    32'h80);
        check("lat gnt1",   {31'd0, gnt_a}, 32'd1);
        check("lat err",    {31'd0, err},   32'd0);
        req_a = 1'b0;
        @(negedge clk);                         // back in IDLE
        check("lat gnt2",   {31'd0, gnt_a}, 32'd0);
        check("lat busy2",  {31'd0, busy},  32'd0);

        // Contention from reset: A first, then alternate every 3 cycles
        do_reset();
        req_a = 1'b1; addr_a = 7'h00; wdata_a = 8'hAA;
        req_b = 1'b1; addr_b = 7'h01; wdata_b = 8'h55;
        ng = 0;
        overlap = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (gnt_a & gnt_b) overlap++;
            if ((gnt_a | gnt_b) && ng < 8) begin
                gport[ng] = gnt_b;
                gcyc[ng]  = c;
                ng++;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        check("cont count", ng, 4);
        check("cont overlap", overlap, 0);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("cont port%0d", g), {31'd0, gport[g]}, {31'd0, logic'(g % 2)});
            check($sformatf("cont cyc%0d", g), gcyc[g], 2 + 3 * g);
        end
        check_regs("cont", 40'hAA_55_00_00_00);
        @(negedge clk);

        // Invalid address from port B
        do_write("inv", 1'b1, 7'h10, 8'hFF, e);
        check("inv err", {31'd0, e}, 32'd1);
        check_regs("inv", 40'hAA_55_00_00_00);

        // Reset during COMMIT, request held and re-served afterwards
        req_a = 1'b1; addr_a = 7'h02; wdata_a = 8'h0F;
        @(negedge clk);                         // COMMIT cycle
        rst = 1'b1;
        @(negedge clk);
        check("rstc pwm",  {24'd0, r2},    32'h00);
        check("rstc gnt",  {31'd0, gnt_a}, 32'd0);
        check("rstc busy", {31'd0, busy},  32'd0);
        check_regs("rstc", 40'h00_00_00_00_00);
        rst = 1'b0;
        do_write("rstc resv", 1'b0, 7'h02, 8'h0F, e);
        check("rstc resv err", {31'd0, e}, 32'd0);
        check("rstc resv pwm", {24'd0, r2}, 32'h0F);

        // Lock register
        do_write("lock a", 1'b0, 7'h05, 8'h01, e);
`ifdef CFG_ARB_LOCK_EN
        check("lock a err", {31'd0, e}, 32'd0);
        do_write("lock b", 1'b1, 7'h03, 8'h33, e);
        check("lock b err", {31'd0, e}, 32'd1);
        check("lock b reg", {24'd0, r3}, 32'h00);
        do_write("lock a wr", 1'b0, 7'h01, 8'h5A, e);
        check("lock a wr err", {31'd0, e}, 32'd0);
        check("lock a wr reg", {24'd0, r1}, 32'h5A);
        do_write("unlock", 1'b0, 7'h05, 8'h00, e);
        do_write("unlock b", 1'b1, 7'h03, 8'h33, e);
        check("unlock b err", {31'd0, e}, 32'd0);
        check("unlock b reg", {24'd0, r3}, 32'h33);
`else
        check("lock a err", {31'd0, e}, 32'd1);
        do_write("lock b", 1'b1, 7'h03, 8'h33, e);
        check("lock b err", {31'd0, e}, 32'd0);
        check("lock b reg", {24'd0, r3}, 32'h33);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
